// File: rtl/multi_axis_stepper_pkg.sv
// ---------------------------------------------------------------------------
// multi_axis_stepper_pkg: shared axis state encoding and bus-slicing helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multi_axis_stepper_pkg;

  typedef enum logic [2:0] {
    AX_IDLE  = 3'd0,
    AX_ARMED = 3'd1,
    AX_SETUP = 3'd2,
    AX_HIGH  = 3'd3,
    AX_LOW   = 3'd4,
    AX_DONE  = 3'd5
  } axis_state_e;

  // Low bit of field idx within a flattened bus of width-wide fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_axis_stepper_axis.sv
// ---------------------------------------------------------------------------
// stepper_axis: one axis FSM with step timing, remaining count and position.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stepper_axis
  import multi_axis_stepper_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int PULSE_W   = 2,
  parameter int DIR_SETUP = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_dir_i,
  input  logic [CNT_W-1:0] cmd_steps_i,
  input  logic [CNT_W-1:0] cmd_period_i,
  input  logic             sync_en_i,
  input  logic             go_i,
  input  logic             abort_i,
  output logic             step_o,
  output logic             dir_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] position_o
);

  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_pulse_w    = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] c_min_period = CNT_W'(PULSE_W + 1);
  localparam logic [CNT_W-1:0] c_setup_last = CNT_W'(DIR_SETUP - 1);

  axis_state_e      state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             w_start_run;
  logic             w_start_high;

  // timer_q holds cycles left in the current timed phase minus one.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    rem_d        = rem_q;
    period_d     = period_q;
    timer_d      = timer_q;
    pos_d        = pos_q;
    w_start_run  = 1'b0;
    w_start_high = 1'b0;

    if (abort_i) begin
      state_d = AX_IDLE;
    end else begin
      case (state_q)
        AX_IDLE: begin
          if (cmd_valid_i) begin
            dir_d    = cmd_dir_i;
            rem_d    = cmd_steps_i;
            period_d = (cmd_period_i < c_min_period) ? c_min_period : cmd_period_i;
            if (cmd_steps_i == '0)  state_d = AX_DONE;
            else if (sync_en_i)     state_d = AX_ARMED;
            else                    w_start_run = 1'b1;
          end
        end
        AX_ARMED: if (go_i) w_start_run = 1'b1;
        AX_SETUP: begin
          if (timer_q == '0) w_start_high = 1'b1;
          else               timer_d = timer_q - c_one;
        end
        AX_HIGH: begin
          if (timer_q == '0) begin
            state_d = AX_LOW;
            timer_d = period_q - c_pulse_w - c_one;
          end else begin
            timer_d = timer_q - c_one;
          end
        end
        AX_LOW: begin
          if (timer_q == '0) begin
            if (rem_q != '0) w_start_high = 1'b1;
            else             state_d = AX_DONE;
          end else begin
            timer_d = timer_q - c_one;
          end
        end
        AX_DONE: state_d = AX_IDLE;
        default: state_d = AX_IDLE;
      endcase
    end

    if (w_start_run) begin
      if (DIR_SETUP == 0) begin
        w_start_high = 1'b1;
      end else begin
        state_d = AX_SETUP;
        timer_d = c_setup_last;
      end
    end

    // rem_d/dir_d already reflect a command latched this cycle.
    if (w_start_high) begin
      state_d = AX_HIGH;
      timer_d = c_pulse_last;
      rem_d   = rem_d - c_one;
      pos_d   = dir_d ? (pos_q + c_one) : (pos_q - c_one);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= AX_IDLE;
      dir_q    <= 1'b0;
      rem_q    <= '0;
      period_q <= '0;
      timer_q  <= '0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      pos_q    <= pos_d;
    end
  end

  assign cmd_ready_o = (state_q == AX_IDLE);
  assign busy_o      = (state_q != AX_IDLE);
  assign step_o      = (state_q == AX_HIGH);
  assign done_o      = (state_q == AX_DONE);
  assign dir_o       = dir_q;
  assign position_o  = pos_q;

endmodule

`default_nettype wire

// File: rtl/multi_axis_stepper.sv
// ---------------------------------------------------------------------------
// multi_axis_stepper: N independent stepper axes sharing sync_en/go.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_axis_stepper
  import multi_axis_stepper_pkg::*;
#(
  parameter int NUM_AXES  = 2,
  parameter int CNT_W     = 32,
  parameter int PULSE_W   = 2,
  parameter int DIR_SETUP = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_AXES-1:0]       cmd_valid,
  output logic [NUM_AXES-1:0]       cmd_ready,
  input  logic [NUM_AXES-1:0]       cmd_dir,
  input  logic [NUM_AXES*CNT_W-1:0] cmd_steps,
  input  logic [NUM_AXES*CNT_W-1:0] cmd_period,
  input  logic                      sync_en,
  input  logic                      go,
  input  logic [NUM_AXES-1:0]       abort,
  output logic [NUM_AXES-1:0]       step_out,
  output logic [NUM_AXES-1:0]       dir_out,
  output logic [NUM_AXES-1:0]       busy,
  output logic [NUM_AXES-1:0]       done,
  output logic [NUM_AXES*CNT_W-1:0] position
);

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    stepper_axis #(
      .CNT_W    (CNT_W),
      .PULSE_W  (PULSE_W),
      .DIR_SETUP(DIR_SETUP)
    ) u_axis (
      .clk_i       (clock),
      .rst_ni      (reset),
      .cmd_valid_i (cmd_valid[i]),
      .cmd_ready_o (cmd_ready[i]),
      .cmd_dir_i   (cmd_dir[i]),
      .cmd_steps_i (cmd_steps[slice_lo(i, CNT_W) +: CNT_W]),
      .cmd_period_i(cmd_period[slice_lo(i, CNT_W) +: CNT_W]),
      .sync_en_i   (sync_en),
      .go_i        (go),
      .abort_i     (abort[i]),
      .step_o      (step_out[i]),
      .dir_o       (dir_out[i]),
      .busy_o      (busy[i]),
      .done_o      (done[i]),
      .position_o  (position[slice_lo(i, CNT_W) +: CNT_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_axis_stepper.sv
// ---------------------------------------------------------------------------
// tb_multi_axis_stepper: directed plus random stimulus against a timing model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multi_axis_stepper;

  localparam int NA = 2;
  localparam int CW = 32;
  localparam int PW = 2;
  localparam int DS = 2;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NA-1:0]    cmd_valid, cmd_ready, cmd_dir, abort;
  logic [NA*CW-1:0] cmd_steps, cmd_period, position;
  logic             sync_en, go;
  logic [NA-1:0]    step_out, dir_out, busy, done;

  always #5 clock = ~clock;

  multi_axis_stepper #(.NUM_AXES(NA), .CNT_W(CW), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .sync_en(sync_en), .go(go), .abort(abort), .step_out(step_out),
    .dir_out(dir_out), .busy(busy), .done(done), .position(position)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a move is a base edge plus arithmetic on step index and period.
  int          m_mode[NA];
  longint      m_base[NA], m_n[NA], m_per[NA], m_kdone[NA];
  bit          m_dir[NA];
  logic [31:0] m_pos0[NA];
  longint      cyc;

  function automatic logic [31:0] pos_at(input int i, input longint k);
    longint cnt;
    if (m_mode[i] != M_RUN || k < DS + 1 || m_n[i] == 0) return m_pos0[i];
    cnt = (k - DS - 1) / m_per[i] + 1;
    if (cnt > m_n[i]) cnt = m_n[i];
    return m_dir[i] ? m_pos0[i] + 32'(cnt) : m_pos0[i] - 32'(cnt);
  endfunction

  function automatic bit step_at(input int i, input longint k);
    longint m;
    if (m_mode[i] != M_RUN || k < DS + 1) return 1'b0;
    m = k - DS - 1;
    return (m / m_per[i] < m_n[i]) && (m % m_per[i] < PW);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_mode[i] = M_IDLE;
      m_dir[i]  = 1'b0;
      m_pos0[i] = '0;
      m_base[i] = 0;
    end
  endtask

  task automatic model_edge();
    longint kprev;
    for (int i = 0; i < NA; i++) begin
      kprev = cyc - m_base[i] + 1;
      if (abort[i] && m_mode[i] != M_IDLE) begin
        if (m_mode[i] == M_RUN) m_pos0[i] = pos_at(i, kprev);
        m_mode[i] = M_IDLE;
      end else if (m_mode[i] == M_RUN && kprev == m_kdone[i]) begin
        m_pos0[i] = pos_at(i, kprev);
        m_mode[i] = M_IDLE;
      end else if (m_mode[i] == M_ARMED && go) begin
        m_mode[i] = M_RUN;
        m_base[i] = cyc + 1;
      end else if (m_mode[i] == M_IDLE && cmd_valid[i] && !abort[i]) begin
        m_dir[i]   = cmd_dir[i];
        m_n[i]     = longint'(cmd_steps[i*CW +: CW]);
        m_per[i]   = longint'(cmd_period[i*CW +: CW]);
        if (m_per[i] < PW + 1) m_per[i] = PW + 1;
        m_kdone[i] = (m_n[i] == 0) ? 1 : DS + m_n[i] * m_per[i] + 1;
        m_base[i]  = cyc + 1;
        m_mode[i]  = (m_n[i] != 0 && sync_en) ? M_ARMED : M_RUN;
      end
    end
    cyc++;
  endtask

  task automatic model_check();
    longint k;
    for (int i = 0; i < NA; i++) begin
      k = cyc - m_base[i] + 1;
      check($sformatf("step%0d", i),  32'(step_out[i]),  32'(step_at(i, k)));
      check($sformatf("dir%0d", i),   32'(dir_out[i]),   32'(m_dir[i]));
      check($sformatf("busy%0d", i),  32'(busy[i]),      32'(m_mode[i] != M_IDLE));
      check($sformatf("ready%0d", i), 32'(cmd_ready[i]), 32'(m_mode[i] == M_IDLE));
      check($sformatf("done%0d", i),  32'(done[i]),      32'(m_mode[i] == M_RUN && k == m_kdone[i]));
      check($sformatf("pos%0d", i),   position[i*CW +: CW], pos_at(i, k));
    end
  endtask

  task automatic do_cycle();
    @(posedge clock);
    if (!reset) model_reset();
    else        model_edge();
    @(negedge clock);
    model_check();
  endtask

  task automatic run(input int n);
    repeat (n) do_cycle();
  endtask

  task automatic send(input int i, input bit d, input logic [31:0] steps, input logic [31:0] per);
    cmd_valid[i]            = 1'b1;
    cmd_dir[i]              = d;
    cmd_steps[i*CW +: CW]   = steps;
    cmd_period[i*CW +: CW]  = per;
  endtask

  task automatic wait_step(input int i, input string tag);
    int guard = 0;
    while (!step_out[i] && guard < 60) begin
      do_cycle();
      guard++;
    end
    check(tag, 32'(step_out[i]), 32'd1);
  endtask

  initial begin
    int seen;
    bit prev;
    cmd_valid = '0; cmd_dir = '0; cmd_steps = '0; cmd_period = '0;
    sync_en = 1'b0; go = 1'b0; abort = '0;
    cyc = 0;
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_step",  32'(step_out), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd3);
    check("rst_pos",   position[31:0], 32'd0);
    run(2);
    reset = 1'b1;
    run(1);

    // Basic move.
    send(0, 1'b1, 32'd3, 32'd5);
    do_cycle();
    cmd_valid = '0;
    run(20);
    check("basic_pos", position[31:0], 32'd3);

    // Period clamp.
    send(0, 1'b1, 32'd2, 32'd1);
    do_cycle();
    cmd_valid = '0;
    run(12);
    check("clamp_pos", position[31:0], 32'd5);

    // Synchronised start.
    sync_en = 1'b1;
    send(0, 1'b0, 32'd4, 32'd4);
    send(1, 1'b1, 32'd2, 32'd8);
    do_cycle();
    cmd_valid = '0;
    run(8);
    check("armed_busy", 32'(busy), 32'd3);
    go = 1'b1;
    do_cycle();
    go = 1'b0;
    sync_en = 1'b0;
    wait_step(0, "sync_first");
    check("sync_same", 32'(step_out[1]), 32'd1);
    run(30);
    check("sync_pos0", position[31:0], 32'd1);
    check("sync_pos1", position[63:32], 32'd2);

    // Abort after third step's rising edge.
    send(0, 1'b1, 32'd10, 32'd5);
    do_cycle();
    cmd_valid = '0;
    seen = 0;
    prev = 1'b0;
    for (int g = 0; g < 100 && seen < 3; g++) begin
      do_cycle();
      if (step_out[0] && !prev) seen++;
      prev = step_out[0];
    end
    check("abort_wait", 32'(seen), 32'd3);
    abort[0] = 1'b1;
    do_cycle();
    abort[0] = 1'b0;
    check("abort_step",  32'(step_out[0]), 32'd0);
    check("abort_pos",   position[31:0], 32'd4);
    check("abort_ready", 32'(cmd_ready[0]), 32'd1);
    run(3);

    // Zero steps, then a command held valid through DONE.
    send(1, 1'b1, 32'd0, 32'd3);
    do_cycle();
    check("zero_done", 32'(done[1]), 32'd1);
    send(1, 1'b0, 32'd2, 32'd3);
    run(2);
    cmd_valid = '0;
    run(12);
    check("b2b_pos", position[63:32], 32'd0);

    // Wrap below zero and a near-maximal step count cut by abort.
    send(0, 1'b0, 32'd5, 32'd3);
    do_cycle();
    cmd_valid = '0;
    run(20);
    check("wrap_pos", position[31:0], 32'hFFFF_FFFF);
    send(1, 1'b1, 32'hFFFF_FFFF, 32'd3);
    do_cycle();
    cmd_valid = '0;
    run(30);
    abort[1] = 1'b1;
    do_cycle();
    abort[1] = 1'b0;
    check("big_idle", 32'(busy[1]), 32'd0);

    // Asynchronous reset in the middle of a HIGH phase.
    send(0, 1'b1, 32'd3, 32'd5);
    do_cycle();
    cmd_valid = '0;
    wait_step(0, "arst_wait");
    #2 reset = 1'b0;
    #1;
    check("arst_step", 32'(step_out[0]), 32'd0);
    check("arst_pos",  position[31:0], 32'd0);
    model_reset();
    run(1);
    reset = 1'b1;
    run(1);
    check("arst_ready", 32'(cmd_ready), 32'd3);

    // Randomised traffic.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 49) == 0) sync_en = ~sync_en;
      go = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NA; i++) begin
        abort[i]     = ($urandom_range(0, 39) == 0);
        cmd_valid[i] = ($urandom_range(0, 3) == 0);
        cmd_dir[i]   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0) cmd_steps[i*CW +: CW] = 32'hFFFF_FFFF;
        else cmd_steps[i*CW +: CW] = 32'($urandom_range(sync_en ? 1 : 0, 5));
        cmd_period[i*CW +: CW] = 32'($urandom_range(0, 7));
      end
      do_cycle();
    end
    cmd_valid = '0;
    go = 1'b0;
    abort = '1;
    do_cycle();
    abort = '0;
    run(2);
    check("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
